linebuffer_kxk: RTL and testbench
=================================

# linebuffer_kxk

Parametrised K×K sliding-window generator for the 2-D convolution datapath. It accepts a raster-order pixel stream (left-to-right, top-to-bottom) over a ready/valid handshake and emits one flattened K×K window per output position to the MAC array. It supports two border modes:
- same-size output with zero padding, including self-generated right and bottom padding and an end-of-frame flush;
- valid-only output.

Backpressure from the consumer stalls the whole block.

## Interface
- PIX_W, 8, pixel width in bits
- IMG_W, 64, image width in pixels (≥ K)
- IMG_H, 64, image height in rows (≥ K)
- K, 3, kernel size; odd, 3..7; R = (K-1)/2
- PAD_MODE, 0: 0 = same-size zero-padded (IMG_W×IMG_H windows); 1 = valid-only ((IMG_W-K+1)×(IMG_H-K+1) windows)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- s_valid  in  1  input pixel valid
- s_ready  out  1  block accepts pixel this cycle
- s_data  in  PIX_W  input pixel
- s_sof  in  1  pixel is (0,0) of a frame
- m_valid  out  1  window valid
- m_ready  in  1  consumer accepts window
- m_win  out  K*K*PIX_W  window; element (r,c) at bits [(r*K+c)*PIX_W +: PIX_W], r=0 top row, c=0 left column
- m_sof  out  1  window is the first of the frame
- m_eol  out  1  window is the last of its output row
- m_eof  out  1  window is the last of the frame
- sof_err  out  1  one-cycle pulse: s_sof accepted mid-frame

## Operation
- Scan counter (sx, sy) walks a virtual grid.
  - PAD_MODE 0: (IMG_W+R)×(IMG_H+R) positions.
  - PAD_MODE 1: IMG_W×IMG_H positions.
- Positions with sx<IMG_W and sy<IMG_H are image positions; they consume one input pixel.
- All other positions are pad positions: they inject value 0 without consuming input.
- K-1 line buffers hold the previous K-1 scan rows (PAD_MODE 0 scan rows include pad columns). A K×K register window shifts in one column per advanced position.
- Advance condition:
  - image position: s_valid && s_ready;
  - pad position: the block is not stalled.
- Stall condition: m_valid && !m_ready. While stalled, nothing advances, s_ready=0, and m_* hold stable.
- States:
  - IDLE: s_ready=1, scan at (0,0). The first accepted beat moves to RUN. A beat accepted in IDLE is treated as (0,0) whatever its s_sof.
  - RUN: advances per the rule above. s_ready = !stall && at an image position.
  - FLUSH (PAD_MODE 0 only): entered after pixel (IMG_W-1, IMG_H-1) is accepted. Generates the remaining pad positions with s_ready=0.
  - Return to IDLE: when the window with m_eof is accepted.
- Window emission:
  - PAD_MODE 0: advancing position (sx,sy) with sx≥R and sy≥R emits the window centred at (sx-R, sy-R). Elements whose source row is <0 or source column is <0 are forced to 0 (masking, not stored data). Right and bottom pad positions contribute 0 naturally.
  - PAD_MODE 1: advancing (sx,sy) with sx≥K-1 and sy≥K-1 emits the window whose top-left is (sx-K+1, sy-K+1).
- Sideband:
  - m_sof: first window of the frame.
  - m_eol: last output column.
  - m_eof: last window. m_eol is also high on that window.
- Resynchronisation: s_sof=1 accepted in RUN at a position other than (0,0):
  - sof_err pulses;
  - scan restarts with this pixel as (0,0);
  - the old frame's remaining windows are dropped. An already-valid output beat is still held until taken.
- Line buffer contents are not reset or cleared between frames. Top/left masking and zero injection guarantee that no stale data reaches m_win.

## Timing
- Reset values: s_ready=0, m_valid=0, m_win=0, m_sof=m_eol=m_eof=0, sof_err=0, state IDLE.
- s_ready rises in the first cycle after rst deasserts.
- Latency: the window is presented (m_valid=1) on the cycle after its triggering position advances. The output is registered, single stage.
- Throughput with m_ready held high:
  - one position per cycle;
  - PAD_MODE 0 input duty is IMG_W/(IMG_W+R) in every row;
  - the flush after the last pixel is R*(IMG_W+R)+R cycles.
- A new frame's first pixel may be accepted in the cycle after the m_eof window is accepted.
- rst asserted mid-frame: all state is cleared immediately and outputs go to reset values. No partial frame resumes.

## Test plan
- K=3, IMG_W=IMG_H=4, PAD_MODE=0, ramp 1..16, m_ready=1 → exactly 16 windows.
  - Centre (0,0) = {0,0,0, 0,1,2, 0,5,6}.
  - Centre (3,3) = {11,12,0, 15,16,0, 0,0,0}.
  - m_sof on the 1st window, m_eol on every 4th, m_eof on the 16th.
- Same config, PAD_MODE=1 → exactly 4 windows; the first is {1,2,3, 5,6,7, 9,10,11}, the last is {6,7,8, 10,11,12, 14,15,16}.
- K=5, IMG_W=IMG_H=8, PAD_MODE=0, random m_ready at 50%, random s_valid gaps → 64 windows, bit-exact to the model. No loss or duplication; m_* stable while stalled.
- Two back-to-back frames with different data → the second frame shows no stale first-frame pixels in its top/left windows. First pixel of frame 2 is accepted ≤1 cycle after frame 1's m_eof is accepted.
- s_sof asserted on pixel 7 of frame 1 → sof_err high for 1 cycle. The subsequent windows match a fresh frame starting at that pixel.
- rst pulsed mid-frame during a stall → all outputs 0 immediately. A full frame sent after reset matches the model.

Source files
------------

// File: rtl/linebuffer_kxk.sv
// K x K sliding-window generator over a raster pixel stream, with zero-padded
// same-size output (PAD_MODE 0) or valid-only output (PAD_MODE 1).
module linebuffer_kxk #(
  parameter int PIX_W    = 8,
  parameter int IMG_W    = 64,
  parameter int IMG_H    = 64,
  parameter int K        = 3,
  parameter int PAD_MODE = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [PIX_W-1:0]       s_data,
  input  logic                   s_sof,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [K*K*PIX_W-1:0]   m_win,
  output logic                   m_sof,
  output logic                   m_eol,
  output logic                   m_eof,
  output logic                   sof_err
);

  localparam int R  = (K - 1) / 2;
  localparam int SW = (PAD_MODE == 0) ? IMG_W + R : IMG_W;
  localparam int SH = (PAD_MODE == 0) ? IMG_H + R : IMG_H;
  localparam int E  = (PAD_MODE == 0) ? R : K - 1;
  localparam int XW = $clog2(SW);
  localparam int YW = $clog2(SH);
  localparam int LW = (K - 1) * PIX_W;

  localparam logic [XW-1:0] X_LAST = XW'(SW - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(SH - 1);
  localparam logic [XW-1:0] X_IMG  = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_IMG  = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_EMIT = XW'(E);
  localparam logic [YW-1:0] Y_EMIT = YW'(E);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t           state;
  logic [XW-1:0]    sx, eff_sx;
  logic [YW-1:0]    sy, eff_sy;
  logic             stall, img_pos, accept, pad_adv, advance, resync, emit, last_pos;
  logic [PIX_W-1:0] pix_in;
  logic [LW-1:0]    lb [SW];
  logic [LW-1:0]    lb_rd;
  logic [PIX_W-1:0] col      [K];
  logic [PIX_W-1:0] win      [K][K];
  logic [PIX_W-1:0] win_next [K][K];
  logic [PIX_W-1:0] win_out  [K][K];

  assign stall   = m_valid && !m_ready;
  assign img_pos = (sx <= X_IMG) && (sy <= Y_IMG);
  // s_ready is combinational so a consumer release is honoured in the same cycle.
  assign s_ready = !rst && !stall && (state == IDLE || (state == RUN && img_pos));
  assign accept  = s_valid && s_ready;
  assign pad_adv = (state == RUN || state == FLUSH) && !img_pos && !stall;
  assign advance = accept || pad_adv;
  assign resync  = accept && s_sof && (state == RUN);

  // A resynchronising pixel is processed as if it sat at (0,0).
  assign eff_sx   = resync ? '0 : sx;
  assign eff_sy   = resync ? '0 : sy;
  assign pix_in   = accept ? s_data : '0;
  assign last_pos = (eff_sx == X_LAST) && (eff_sy == Y_LAST);
  assign emit     = advance && (eff_sx >= X_EMIT) && (eff_sy >= Y_EMIT);
  assign lb_rd    = lb[eff_sx];

  // NOTE: every element is assigned on every pass, so no latches are inferred.
  always_comb begin
    col[K-1] = pix_in;
    for (int j = 1; j < K; j++) col[K-1-j] = lb_rd[(j-1)*PIX_W +: PIX_W];
  end

  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) win_next[r][c] = win[r][c+1];
      win_next[r][K-1] = col[r];
    end
  end

  // Top/left elements outside the image are masked, hiding stale buffer data.
  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win_out[r][c] = win_next[r][c];
        if (PAD_MODE == 0 && ((r + int'(eff_sy) < 2 * R) || (c + int'(eff_sx) < 2 * R)))
          win_out[r][c] = '0;
      end
    end
  end

  // NOTE: line-buffer storage is deliberately not reset; masking covers stale rows.
  always_ff @(posedge clk) begin
    if (advance) lb[eff_sx] <= {lb_rd[LW-PIX_W-1:0], pix_in};
  end

  // NOTE: all sequential state uses non-blocking assignments to avoid races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sx      <= '0;
      sy      <= '0;
      m_valid <= 1'b0;
      m_win   <= '0;
      m_sof   <= 1'b0;
      m_eol   <= 1'b0;
      m_eof   <= 1'b0;
      sof_err <= 1'b0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win[r][c] <= '0;
    end else begin
      sof_err <= resync;
      if (!stall) begin
        m_valid <= emit;
        if (emit) begin
          for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++) m_win[(r*K+c)*PIX_W +: PIX_W] <= win_out[r][c];
          m_sof <= (eff_sx == X_EMIT) && (eff_sy == Y_EMIT);
          m_eol <= (eff_sx == X_LAST);
          m_eof <= last_pos;
        end
      end
      if (advance) begin
        win <= win_next;
        if (last_pos) begin
          state <= DONE;
          sx    <= '0;
          sy    <= '0;
        end else begin
          if (PAD_MODE == 0 && eff_sx == X_IMG && eff_sy == Y_IMG) state <= FLUSH;
          else if (state == IDLE)                                  state <= RUN;
          if (eff_sx == X_LAST) begin
            sx <= '0;
            sy <= eff_sy + YW'(1);
          end else begin
            sx <= eff_sx + XW'(1);
            sy <= eff_sy;
          end
        end
      end else if (state == DONE && m_valid && m_ready && m_eof) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_linebuffer_kxk.sv
// Directed bench for linebuffer_kxk: hand-computed window table, frame model,
// resync, back-to-back frames and reset during a stall.
module tb_linebuffer_kxk;

  typedef struct packed {
    logic         sof;
    logic         eol;
    logic         eof;
    logic [199:0] win;
  } beat_t;

  typedef struct {
    int   tst;
    int   idx;
    int   pix [9];
    logic sof;
    logic eol;
    logic eof;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int          sel = 0;
  logic        sv = 1'b0, ss = 1'b0, mr = 1'b1;
  logic [7:0]  sd = '0;

  logic        sr0, mv0, sof0, eol0, eof0, err0;
  logic        sr1, mv1, sof1, eol1, eof1, err1;
  logic        sr2, mv2, sof2, eol2, eof2, err2;
  logic [71:0]  mw0, mw1;
  logic [199:0] mw2;

  logic         sr, mv, msof, meol, meof, serr;
  logic [199:0] mw;

  linebuffer_kxk #(.PIX_W(8), .IMG_W(4), .IMG_H(4), .K(3), .PAD_MODE(0)) u0 (
    .clk(clk), .rst(rst), .s_valid(sv && sel == 0), .s_ready(sr0), .s_data(sd), .s_sof(ss),
    .m_valid(mv0), .m_ready(mr), .m_win(mw0), .m_sof(sof0), .m_eol(eol0), .m_eof(eof0),
    .sof_err(err0));

  linebuffer_kxk #(.PIX_W(8), .IMG_W(4), .IMG_H(4), .K(3), .PAD_MODE(1)) u1 (
    .clk(clk), .rst(rst), .s_valid(sv && sel == 1), .s_ready(sr1), .s_data(sd), .s_sof(ss),
    .m_valid(mv1), .m_ready(mr), .m_win(mw1), .m_sof(sof1), .m_eol(eol1), .m_eof(eof1),
    .sof_err(err1));

  linebuffer_kxk #(.PIX_W(8), .IMG_W(8), .IMG_H(8), .K(5), .PAD_MODE(0)) u2 (
    .clk(clk), .rst(rst), .s_valid(sv && sel == 2), .s_ready(sr2), .s_data(sd), .s_sof(ss),
    .m_valid(mv2), .m_ready(mr), .m_win(mw2), .m_sof(sof2), .m_eol(eol2), .m_eof(eof2),
    .sof_err(err2));

  always_comb begin
    sr = sr0; mv = mv0; mw = 200'(mw0); msof = sof0; meol = eol0; meof = eof0; serr = err0;
    case (sel)
      1: begin sr = sr1; mv = mv1; mw = 200'(mw1); msof = sof1; meol = eol1; meof = eof1; serr = err1; end
      2: begin sr = sr2; mv = mv2; mw = mw2;       msof = sof2; meol = eol2; meof = eof2; serr = err2; end
      default: ;
    endcase
  end

  int total = 0;
  int bad   = 0;

  logic [7:0] src_d [$];
  logic       src_s [$];
  beat_t      exp_q [$];
  beat_t      got   [$];
  int         got_cyc [$];
  int         acc_cyc [$];
  int         eof_cyc [$];
  int         serr_n;
  int         img [8][8];
  vec_t       vt [8];

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic check_beat(input string name, input int i, input beat_t act, input beat_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got=%h want=%h", name, i, act, exp);
    end
  endtask

  task automatic clear_all();
    src_d.delete(); src_s.delete(); exp_q.delete();
  endtask

  // Appends one frame to the source stream and records it as the model image.
  task automatic load_frame(input int w, input int h, input int base, input int step);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) img[y][x] = 0;
    for (int i = 0; i < w * h; i++) begin
      img[i / w][i % w] = (base + step * i) & 255;
      src_d.push_back(8'((base + step * i) & 255));
      src_s.push_back(i == 0);
    end
  endtask

  // Reference windows straight from the image: out-of-range pixels read as 0.
  task automatic model(input int k, input int w, input int h, input int pad, input int max_n);
    int rr, ow, oh, off, n, y, x, v;
    beat_t b;
    rr  = (k - 1) / 2;
    ow  = pad ? w - k + 1 : w;
    oh  = pad ? h - k + 1 : h;
    off = pad ? 0 : -rr;
    n   = 0;
    for (int oy = 0; oy < oh; oy++) begin
      for (int ox = 0; ox < ow; ox++) begin
        if (max_n >= 0 && n >= max_n) return;
        b = '0;
        for (int r = 0; r < k; r++) begin
          for (int c = 0; c < k; c++) begin
            y = oy + off + r;
            x = ox + off + c;
            v = (y >= 0 && y < h && x >= 0 && x < w) ? img[y][x] : 0;
            b.win[(r*k+c)*8 +: 8] = 8'(v);
          end
        end
        b.sof = (ox == 0 && oy == 0);
        b.eol = (ox == ow - 1);
        b.eof = (ox == ow - 1 && oy == oh - 1);
        exp_q.push_back(b);
        n++;
      end
    end
  endtask

  // Drives src_* and collects accepted windows; entered and left at posedge+1.
  task automatic stream(input int n_win, input int gap_pct, input int rdy_pct, input int budget);
    int    idx, n, tail;
    logic  have_held;
    beat_t held, cur;
    idx = 0; n = 0; tail = 0; have_held = 1'b0; held = '0;
    got.delete(); got_cyc.delete(); acc_cyc.delete(); eof_cyc.delete(); serr_n = 0;
    while (tail < 8) begin
      sv = (idx < src_d.size()) && ($urandom_range(99) >= gap_pct);
      sd = (idx < src_d.size()) ? src_d[idx] : 8'h00;
      ss = (idx < src_d.size()) ? src_s[idx] : 1'b0;
      mr = ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      cur = {msof, meol, meof, mw};
      if (have_held) begin
        check_int("stall_valid", int'(mv), 1);
        check_beat("stall_hold", n, cur, held);
      end
      have_held = mv && !mr;
      held = cur;
      if (sv && sr) begin
        acc_cyc.push_back(n);
        idx++;
      end
      if (mv && mr) begin
        got.push_back(cur);
        got_cyc.push_back(n);
        if (meof) eof_cyc.push_back(n);
      end
      if (serr) serr_n++;
      n++;
      if (idx == src_d.size() && got.size() >= n_win) tail++;
      if (n > budget) begin
        check_int("stream_timeout_windows", got.size(), n_win);
        tail = 8;
      end
      @(posedge clk);
      #1;
    end
    sv = 1'b0; ss = 1'b0; mr = 1'b1;
  endtask

  task automatic compare_all(input string name);
    check_int({name, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) check_beat(name, i, got[i], exp_q[i]);
  endtask

  task automatic apply_vectors(input int tst);
    beat_t e;
    for (int i = 0; i < 8; i++) begin
      if (vt[i].tst == tst) begin
        e = '0;
        for (int j = 0; j < 9; j++) e.win[j*8 +: 8] = 8'(vt[i].pix[j]);
        e.sof = vt[i].sof; e.eol = vt[i].eol; e.eof = vt[i].eof;
        if (vt[i].idx < got.size()) check_beat("vec", vt[i].idx, got[vt[i].idx], e);
        else check_int("vec_missing", got.size(), vt[i].idx + 1);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    vt[0] = '{0,  0, '{0, 0, 0,  0, 1, 2,   0, 5, 6},    1'b1, 1'b0, 1'b0};
    vt[1] = '{0,  3, '{0, 0, 0,  3, 4, 0,   7, 8, 0},    1'b0, 1'b1, 1'b0};
    vt[2] = '{0,  5, '{1, 2, 3,  5, 6, 7,   9, 10, 11},  1'b0, 1'b0, 1'b0};
    vt[3] = '{0, 12, '{0, 9, 10, 0, 13, 14, 0, 0, 0},    1'b0, 1'b0, 1'b0};
    vt[4] = '{0, 15, '{11, 12, 0, 15, 16, 0, 0, 0, 0},   1'b0, 1'b1, 1'b1};
    vt[5] = '{1,  0, '{1, 2, 3,  5, 6, 7,   9, 10, 11},  1'b1, 1'b0, 1'b0};
    vt[6] = '{1,  1, '{2, 3, 4,  6, 7, 8,   10, 11, 12}, 1'b0, 1'b1, 1'b0};
    vt[7] = '{1,  3, '{6, 7, 8,  10, 11, 12, 14, 15, 16}, 1'b0, 1'b1, 1'b1};

    // Reset values while rst is held.
    #2;
    check_int("rst_s_ready", int'(sr), 0);
    check_int("rst_m_valid", int'(mv), 0);
    check_int("rst_m_win_nonzero", int'(|mw), 0);
    check_int("rst_sideband", int'({msof, meol, meof}), 0);
    check_int("rst_sof_err", int'(serr), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_int("s_ready_after_rst", int'(sr), 1);
    @(posedge clk); #1;

    // K=3 4x4 zero-padded ramp, full rate.
    sel = 0; clear_all();
    load_frame(4, 4, 1, 1);
    model(3, 4, 4, 0, -1);
    stream(16, 0, 100, 300);
    compare_all("pad0_ramp");
    apply_vectors(0);
    if (acc_cyc.size() == 16 && eof_cyc.size() == 1) begin
      check_int("first_latency", got_cyc[0] - acc_cyc[5], 1);
      check_int("row_duty_gap", acc_cyc[4] - acc_cyc[3], 2);
      check_int("flush_len", eof_cyc[0] - acc_cyc[15], 7);
    end else begin
      check_int("pad0_accepts", acc_cyc.size(), 16);
    end

    // K=3 4x4 valid-only.
    sel = 1; clear_all();
    load_frame(4, 4, 1, 1);
    model(3, 4, 4, 1, -1);
    stream(4, 0, 100, 300);
    compare_all("pad1_ramp");
    apply_vectors(1);

    // Back-to-back frames with different data, full rate.
    sel = 0; clear_all();
    load_frame(4, 4, 100, 1);
    model(3, 4, 4, 0, -1);
    load_frame(4, 4, 200, 3);
    model(3, 4, 4, 0, -1);
    stream(32, 0, 100, 400);
    compare_all("b2b");
    if (acc_cyc.size() == 32 && eof_cyc.size() == 2)
      check_int("b2b_restart_gap", acc_cyc[16] - eof_cyc[0], 1);
    else
      check_int("b2b_eofs", eof_cyc.size(), 2);

    // Resync: s_sof on the 8th pixel (index 7) starts a fresh frame.
    sel = 0; clear_all();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) img[y][x] = 0;
    for (int i = 0; i < 7; i++) begin
      img[i / 4][i % 4] = 50 + i;
      src_d.push_back(8'(50 + i));
      src_s.push_back(i == 0);
    end
    model(3, 4, 4, 0, 2);
    load_frame(4, 4, 150, 1);
    model(3, 4, 4, 0, -1);
    stream(18, 0, 100, 400);
    compare_all("resync");
    check_int("sof_err_cycles", serr_n, 1);

    // K=5 8x8 with random input gaps and consumer backpressure.
    sel = 2; clear_all();
    load_frame(8, 8, 3, 7);
    model(5, 8, 8, 0, -1);
    stream(64, 30, 50, 3000);
    compare_all("k5_random");

    // Reset asserted mid-frame while the output is stalled.
    sel = 2; mr = 1'b0; idx = 0;
    for (int i = 0; i < 100 && !mv; i++) begin
      sv = 1'b1; sd = 8'(idx); ss = (idx == 0);
      @(negedge clk);
      if (sv && sr) idx++;
      @(posedge clk); #1;
    end
    sv = 1'b0; ss = 1'b0;
    check_int("stall_before_rst_valid", int'(mv), 1);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_int("midrst_s_ready", int'(sr), 0);
    check_int("midrst_m_valid", int'(mv), 0);
    check_int("midrst_m_win_nonzero", int'(|mw), 0);
    check_int("midrst_sideband", int'({msof, meol, meof, serr}), 0);
    @(posedge clk); #1 rst = 1'b0;
    mr = 1'b1;
    clear_all();
    load_frame(8, 8, 9, 5);
    model(5, 8, 8, 0, -1);
    stream(64, 10, 70, 3000);
    compare_all("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
